// File: rtl/spi_flash_reader_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_reader_pkg
// Shared definitions for the SPI flash read sequencer: FSM state encoding,
// header length, flash opcodes, and the header byte selector.
// -----------------------------------------------------------------------------
package spi_flash_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_HOLD,
        ST_DONE
    } state_e;

    // Opcode byte plus three address bytes precede the data phase.
    localparam int unsigned HDR_BYTES = 4;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;

    // Header byte by position: opcode, then address MSB first.
    function automatic logic [7:0] header_byte(input logic [1:0]  sel,
                                               input logic [7:0]  cmd,
                                               input logic [23:0] addr);
        logic [7:0] b;
        case (sel)
            2'd0:    b = cmd;
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
// Sequences one flash READ transaction on top of an SPI byte engine: drops
// chip select, sends opcode + 24-bit address, then clocks dummy bytes and
// returns each received data byte on a one-cycle strobe.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               request pulse, sampled only while idle
//   addr_i, len_i         start address and byte count, latched on start
//   rd_data_o, rd_valid_o received data byte and its strobe
//   done_o                end-of-transaction strobe
//   ctrl_busy_o           high from accepted start through the done cycle
//   flash_cs_n_o          flash chip select, active low
//   spi_tx_data_o         byte handed to the engine
//   spi_write_o           one-cycle write pulse to the engine
//   spi_busy_i            engine busy
//   spi_rx_data_i         engine received byte, valid once busy falls
// -----------------------------------------------------------------------------
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int unsigned LEN_W      = 16,
    parameter logic [7:0]  READ_CMD   = OP_READ,
    parameter logic [7:0]  DUMMY_BYTE = 8'h00,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic             ctrl_busy_o,
    output logic             flash_cs_n_o,
    output logic [7:0]       spi_tx_data_o,
    output logic             spi_write_o,
    input  logic             spi_busy_i,
    input  logic [7:0]       spi_rx_data_i
);

    // One down-counter serves both chip-select setup and hold timing.
    localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Byte index spans header + up to 2^LEN_W-1 data bytes without overflow.
    localparam int unsigned IDX_W   = LEN_W + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
    localparam logic [IDX_W-1:0] HDR_CNT    = IDX_W'(HDR_BYTES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [23:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         tx_q, tx_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               cs_n_q, cs_n_d;
    logic               write_q, write_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               cnt_zero;
    logic [IDX_W-1:0]   idx_inc;
    logic               last_byte;

    assign cnt_zero  = (cnt_q == '0);
    assign idx_inc   = idx_q + IDX_W'(1);
    assign last_byte = (idx_inc == (IDX_W'(len_q) + HDR_CNT));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i) begin
        // NOTE: clocked blocks use non-blocking (<=) so every register samples
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every combinational output gets a default first; any path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? ST_SETUP : ST_DONE;
                end
            end
            ST_SETUP:     if (cnt_zero)    state_d = ST_ISSUE;
            ST_ISSUE:                      state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: if (spi_busy_i)  state_d = ST_WAIT_FALL;
            ST_WAIT_FALL: begin
                if (!spi_busy_i) begin
                    state_d = last_byte ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_HOLD:      if (cnt_zero)    state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        tx_d       = tx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        // Handshake outputs are decoded from the next state and registered,
        // so chip select and strobes are glitch-free and line up with state.
        cs_n_d  = !(state_d inside {ST_SETUP, ST_ISSUE, ST_WAIT_RISE, ST_WAIT_FALL});
        write_d = (state_d == ST_ISSUE);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    addr_d = addr_i;
                    len_d  = len_i;
                    idx_d  = '0;
                    cnt_d  = SETUP_LOAD;
                end
            end
            ST_SETUP, ST_HOLD: begin
                if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            end
            ST_WAIT_FALL: begin
                if (!spi_busy_i) begin
                    idx_d = idx_inc;
                    if (idx_q >= HDR_CNT) begin
                        rd_data_d  = spi_rx_data_i;
                        rd_valid_d = 1'b1;
                    end
                    if (last_byte) cnt_d = HOLD_LOAD;
                end
            end
            default: ;
        endcase

        // Load the outgoing byte on ISSUE entry; it holds until the next ISSUE.
        if (state_d == ST_ISSUE) begin
            tx_d = (idx_d < HDR_CNT) ? header_byte(idx_d[1:0], READ_CMD, addr_q)
                                     : DUMMY_BYTE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            tx_q       <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            tx_q       <= tx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cs_n_q     <= cs_n_d;
            write_q    <= write_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign done_o        = done_q;
    assign ctrl_busy_o   = busy_q;
    assign flash_cs_n_o  = cs_n_q;
    assign spi_tx_data_o = tx_q;
    assign spi_write_o   = write_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_reader
// Drives spi_flash_reader against a byte-engine + flash model and compares
// every write, read strobe and done pulse with a transaction-level model.
// -----------------------------------------------------------------------------
module tb_spi_flash_reader;

    localparam int LEN_W    = 16;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int BUSY_CYC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             done;
    logic             ctrl_busy;
    logic             flash_cs_n;
    logic [7:0]       spi_tx_data;
    logic             spi_write;
    logic             spi_busy;
    logic [7:0]       spi_rx_data;

    spi_flash_reader #(
        .LEN_W     (LEN_W),
        .READ_CMD  (8'h03),
        .DUMMY_BYTE(8'h00),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .addr_i       (addr),
        .len_i        (len),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .done_o       (done),
        .ctrl_busy_o  (ctrl_busy),
        .flash_cs_n_o (flash_cs_n),
        .spi_tx_data_o(spi_tx_data),
        .spi_write_o  (spi_write),
        .spi_busy_i   (spi_busy),
        .spi_rx_data_i(spi_rx_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- flash contents
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hAA;
            24'h012346: return 8'hBB;
            24'h012347: return 8'hCC;
            default:    return (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'h3C;
        endcase
    endfunction

    // ---------------------------------------------------------------- reference model
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    int         pending = 0;

    // A READ of len bytes at a: opcode, address MSB first, len dummies on the
    // wire; flash bytes a, a+1, ... (24-bit wrap done by the flash) returned.
    task automatic push_txn(input logic [23:0] a, input logic [LEN_W-1:0] l);
        pending++;
        if (l != 0) begin
            exp_tx.push_back(8'h03);
            exp_tx.push_back(a[23:16]);
            exp_tx.push_back(a[15:8]);
            exp_tx.push_back(a[7:0]);
            for (int k = 0; k < int'(l); k++) begin
                exp_tx.push_back(8'h00);
                exp_rd.push_back(flash_byte(a + 24'(k)));
            end
        end
    endtask

    // ---------------------------------------------------------------- byte engine + flash
    int          stall_cyc = 0;
    int          fl_idx    = 0;
    logic [23:0] fl_addr   = '0;
    logic [7:0]  eng_b, eng_rx;
    logic [7:0]  eng_log[$];

    initial begin
        spi_busy    = 1'b0;
        spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (flash_cs_n) fl_idx = 0;
            if (spi_write) begin
                eng_b = spi_tx_data;
                eng_log.push_back(eng_b);
                case (fl_idx)
                    1: fl_addr[23:16] = eng_b;
                    2: fl_addr[15:8]  = eng_b;
                    3: fl_addr[7:0]   = eng_b;
                    default: ;
                endcase
                eng_rx = (fl_idx >= 4) ? flash_byte(fl_addr + 24'(fl_idx - 4)) : 8'hFF;
                fl_idx++;
                repeat (stall_cyc) @(negedge clk);
                spi_busy = 1'b1;
                repeat (BUSY_CYC) @(negedge clk);
                spi_busy    = 1'b0;
                spi_rx_data = eng_rx;
            end
        end
    end

    // ---------------------------------------------------------------- compare process
    int         w_total = 0, rd_total = 0, done_total = 0, cs_falls = 0;
    int         high_run = 0, since_fall = 0;
    logic       cs_prev = 1'b1, busy_prev = 1'b0, seen_low = 1'b0;
    logic       first_wr = 1'b0, done_since_rise = 1'b1;
    logic [7:0] rd_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cs_prev         = 1'b1;
                busy_prev       = 1'b0;
                seen_low        = 1'b0;
                first_wr        = 1'b0;
                high_run        = 0;
                done_since_rise = 1'b1;
            end else begin
                if (!flash_cs_n && cs_prev) begin
                    cs_falls++;
                    check("cs_fall_while_busy", 32'(ctrl_busy), 1);
                    if (seen_low) check("cs_hold_gap", 32'(high_run >= CS_HOLD), 1);
                    seen_low   = 1'b1;
                    since_fall = 0;
                    first_wr   = 1'b1;
                    high_run   = 0;
                end else begin
                    since_fall++;
                end
                if (flash_cs_n) high_run++;

                if (ctrl_busy && !busy_prev) begin
                    check("done_before_busy_rise", 32'(done_since_rise), 1);
                    done_since_rise = 1'b0;
                end

                if (spi_write) begin
                    w_total++;
                    check("cs_low_on_write", 32'(flash_cs_n), 0);
                    if (first_wr) begin
                        check("cs_setup_cycles", 32'(since_fall), CS_SETUP);
                        first_wr = 1'b0;
                    end
                    check("write_expected", 32'(exp_tx.size() != 0), 1);
                    if (exp_tx.size() != 0) check("tx_byte", 32'(spi_tx_data), 32'(exp_tx.pop_front()));
                end

                if (rd_valid) begin
                    rd_total++;
                    rd_log.push_back(rd_data);
                    check("rd_expected", 32'(exp_rd.size() != 0), 1);
                    if (exp_rd.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                end

                if (done) begin
                    done_total++;
                    check("done_pending", 32'(pending > 0), 1);
                    if (pending > 0) pending--;
                    check("done_all_tx_sent", 32'(exp_tx.size()), 0);
                    check("done_after_last_rd", 32'(exp_rd.size()), 0);
                    check("busy_during_done", 32'(ctrl_busy), 1);
                    done_since_rise = 1'b1;
                end

                cs_prev   = flash_cs_n;
                busy_prev = ctrl_busy;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic launch(input logic [23:0] a, input logic [LEN_W-1:0] l);
        int t = 0;
        while (ctrl_busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle_before_start", 32'(ctrl_busy), 0);
        start = 1'b1;
        addr  = a;
        len   = l;
        push_txn(a, l);
        @(negedge clk);
        start = 1'b0;
        addr  = 24'($urandom);
        len   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (!done && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", 32'(t < limit), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    logic [7:0]  exp_seq[7];
    logic [7:0]  exp_dat[3];
    int          w0, d0, f0, r0, t;
    logic [23:0] ra;
    logic [LEN_W-1:0] rl;

    initial begin
        exp_seq = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00};
        exp_dat = '{8'hAA, 8'hBB, 8'hCC};
        rst   = 1'b1;
        start = 1'b0;
        addr  = '0;
        len   = '0;
        repeat (3) @(negedge clk);

        check("rst_cs_n",     32'(flash_cs_n),  1);
        check("rst_write",    32'(spi_write),   0);
        check("rst_tx_data",  32'(spi_tx_data), 0);
        check("rst_rd_valid", 32'(rd_valid),    0);
        check("rst_rd_data",  32'(rd_data),     0);
        check("rst_done",     32'(done),        0);
        check("rst_busy",     32'(ctrl_busy),   0);
        rst = 1'b0;
        @(negedge clk);

        // Directed READ: 03 01 23 45 + three dummies, data AA BB CC.
        eng_log.delete();
        rd_log.delete();
        d0 = done_total;
        launch(24'h012345, 3);
        wait_done(400);
        check("dir_write_count", 32'(eng_log.size()), 7);
        for (int i = 0; i < 7; i++)
            if (i < eng_log.size()) check("dir_tx_seq", 32'(eng_log[i]), 32'(exp_seq[i]));
        check("dir_rd_count", 32'(rd_log.size()), 3);
        for (int i = 0; i < 3; i++)
            if (i < rd_log.size()) check("dir_rd_seq", 32'(rd_log[i]), 32'(exp_dat[i]));
        check("dir_done_once", 32'(done_total - d0), 1);

        // len = 0: done one cycle later, chip select untouched, no writes.
        @(negedge clk);
        w0 = w_total;
        f0 = cs_falls;
        launch(24'h000100, 0);
        check("len0_done_next_cycle", 32'(done), 1);
        repeat (5) @(negedge clk);
        check("len0_no_write", 32'(w_total - w0), 0);
        check("len0_cs_untouched", 32'(cs_falls - f0), 0);

        // start with a different address during the 2nd address byte is ignored.
        w0 = w_total;
        launch(24'h00ABCD, 4);
        t = 0;
        while ((w_total - w0) < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        start = 1'b1;
        addr  = 24'hFFFFFF;
        len   = 5;
        @(negedge clk);
        start = 1'b0;
        wait_done(500);
        repeat (20) @(negedge clk);
        check("ignored_start_no_txn", 32'(ctrl_busy), 0);
        check("ignored_start_writes", 32'(w_total - w0), 8);

        // Engine delays busy rise by 5 cycles: still one write per byte.
        stall_cyc = 5;
        w0 = w_total;
        launch(24'h7FFFFE, 4);
        wait_done(800);
        check("stall_one_write_per_byte", 32'(w_total - w0), 8);
        stall_cyc = 0;

        // Reset during the 2nd data byte, then a clean transfer.
        @(negedge clk);
        w0 = w_total;
        d0 = done_total;
        launch(24'h1000F0, 6);
        t = 0;
        while ((w_total - w0) < 6 && t < 800) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n",     32'(flash_cs_n), 1);
        check("abort_busy",     32'(ctrl_busy),  0);
        check("abort_rd_valid", 32'(rd_valid),   0);
        check("abort_write",    32'(spi_write),  0);
        check("abort_done",     32'(done),       0);
        exp_tx.delete();
        exp_rd.delete();
        pending = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_total - d0), 0);
        r0 = rd_total;
        launch(24'h1000F0, 6);
        wait_done(800);
        check("after_abort_rd_count", 32'(rd_total - r0), 6);

        // start held high: three back-to-back transfers.
        @(negedge clk);
        d0    = done_total;
        start = 1'b1;
        addr  = 24'h00FF00;
        len   = 2;
        push_txn(24'h00FF00, 2);
        for (int i = 0; i < 3; i++) begin
            wait_done(600);
            if (i < 2) begin
                @(negedge clk);
                push_txn(24'h00FF00, 2);
            end else begin
                start = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        check("b2b_done_count", 32'(done_total - d0), 3);

        // Randomized transfers, including addresses that cross 24'hFFFFFF.
        for (int n = 0; n < 14; n++) begin
            stall_cyc = $urandom_range(0, 3);
            ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                             : 24'($urandom);
            rl = LEN_W'($urandom_range(0, 7));
            launch(ra, rl);
            wait_done((int'(rl) + 4) * 20 + 50);
        end

        repeat (10) @(negedge clk);
        check("final_pending", 32'(pending), 0);
        check("final_tx_empty", 32'(exp_tx.size()), 0);
        check("final_rd_empty", 32'(exp_rd.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
